// File: rtl/burst_serializer_mono8.sv
// Mono8 burst-to-pixel serializer: unpacks wide bursts into one 8-bit pixel per beat,
// tagging each pixel with raster coordinates, end-of-frame and per-frame start/done control.
module burst_serializer_mono8 #(
  parameter int IN_ROWS          = 20,
  parameter int IN_COLS          = 20,
  parameter int PIXELS_PER_BURST = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ap_start,
  output logic                            ap_idle,
  output logic                            ap_done,
  output logic                            frame_err,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [8*PIXELS_PER_BURST-1:0]   s_axis_tdata,
  input  logic                            s_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [7:0]                      m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic [$clog2(IN_COLS)-1:0]      cnt_col,
  output logic [$clog2(IN_ROWS)-1:0]      cnt_row
);
  localparam int CW = $clog2(IN_COLS);
  localparam int RW = $clog2(IN_ROWS);
  localparam int DW = 8 * PIXELS_PER_BURST;
  localparam int HW = $clog2(PIXELS_PER_BURST + 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IN_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IN_ROWS - 1);
  localparam logic [HW-1:0] HELD_FULL = HW'(PIXELS_PER_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [DW-1:0] shreg_r, shreg_s;
  logic [HW-1:0] held_r, held_s;
  logic [CW-1:0] col_r, col_s;
  logic [RW-1:0] row_r, row_s;
  logic          tvalid_r, tvalid_s;
  logic          tlast_r, tlast_s;
  logic          idle_r, idle_s;
  logic          done_r, done_s;
  logic          err_r, err_s;
  logic          m_hs_s, s_hs_s, s_ready_s;

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_s   = state_r;
    shreg_s   = shreg_r;
    held_s    = held_r;
    col_s     = col_r;
    row_s     = row_r;
    done_s    = 1'b0;
    err_s     = 1'b0;
    s_ready_s = 1'b0;
    s_hs_s    = 1'b0;
    m_hs_s    = tvalid_r && m_axis_tready;
    case (state_r)
      IDLE: begin
        if (ap_start) begin
          state_s = SYNC;
        end else begin
          state_s = IDLE;
        end
      end
      SYNC: begin
        s_ready_s = 1'b1;
        s_hs_s    = s_axis_tvalid;
        if (s_hs_s && s_axis_tuser) begin
          shreg_s = s_axis_tdata;
          held_s  = HELD_FULL;
          col_s   = {CW{1'b0}};
          row_s   = {RW{1'b0}};
          state_s = RUN;
        end else begin
          state_s = SYNC;
        end
      end
      RUN: begin
        // Reload while the last held pixel leaves, but never past the frame's final pixel.
        s_ready_s = (held_r == {HW{1'b0}}) ||
                    ((held_r == HW'(1)) && m_axis_tready && !tlast_r);
        s_hs_s    = s_ready_s && s_axis_tvalid;
        if (m_hs_s && tlast_r) begin
          state_s = DONE;
          shreg_s = {DW{1'b0}};
          held_s  = {HW{1'b0}};
          col_s   = {CW{1'b0}};
          row_s   = {RW{1'b0}};
          done_s  = 1'b1;
        end else begin
          if (m_hs_s) begin
            shreg_s = {8'h00, shreg_r[DW-1:8]};
            held_s  = held_r - HW'(1);
            if (col_r == COL_LAST) begin
              col_s = {CW{1'b0}};
              row_s = row_r + RW'(1);
            end else begin
              col_s = col_r + CW'(1);
            end
          end else begin
            held_s = held_r;
          end
          if (s_hs_s) begin
            shreg_s = s_axis_tdata;
            held_s  = HELD_FULL;
            if (s_axis_tuser) begin
              col_s = {CW{1'b0}};
              row_s = {RW{1'b0}};
              err_s = 1'b1;
            end else begin
              err_s = 1'b0;
            end
          end else begin
            s_hs_s = 1'b0;
          end
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        shreg_s = {DW{1'b0}};
        held_s  = {HW{1'b0}};
        col_s   = {CW{1'b0}};
        row_s   = {RW{1'b0}};
      end
    endcase
    tvalid_s = (state_s == RUN) && (held_s != {HW{1'b0}});
    tlast_s  = tvalid_s && (col_s == COL_LAST) && (row_s == ROW_LAST);
    idle_s   = (state_s == IDLE);
  end

  // State, shift register, coordinates and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      shreg_r  <= {DW{1'b0}};
      held_r   <= {HW{1'b0}};
      col_r    <= {CW{1'b0}};
      row_r    <= {RW{1'b0}};
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      idle_r   <= 1'b1;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      shreg_r  <= shreg_s;
      held_r   <= held_s;
      col_r    <= col_s;
      row_r    <= row_s;
      tvalid_r <= tvalid_s;
      tlast_r  <= tlast_s;
      idle_r   <= idle_s;
      done_r   <= done_s;
      err_r    <= err_s;
    end
  end

  assign ap_idle       = idle_r;
  assign ap_done       = done_r;
  assign frame_err     = err_r;
  assign s_axis_tready = s_ready_s;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tdata  = shreg_r[7:0];
  assign m_axis_tlast  = tlast_r;
  assign cnt_col       = col_r;
  assign cnt_row       = row_r;

endmodule

// File: tb/tb_burst_serializer_mono8.sv
// Randomized self-checking bench for burst_serializer_mono8 against a queue-based pixel model.
module tb_burst_serializer_mono8;
  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int PPB  = 4;
  localparam int CW   = $clog2(COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int DW   = 8 * PPB;
  localparam int NPIX = ROWS * COLS;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_idle, ap_done, frame_err;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tuser = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tlast;
  logic [CW-1:0] cnt_col;
  logic [RW-1:0] cnt_row;

  burst_serializer_mono8 #(.IN_ROWS(ROWS), .IN_COLS(COLS), .PIXELS_PER_BURST(PPB)) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
    .frame_err(frame_err), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .cnt_col(cnt_col), .cnt_row(cnt_row)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; logic tuser; int after; } beat_t;
  typedef struct { int data; int col; int row; int last; } pix_t;

  beat_t src_q[$];
  pix_t  exp_q[$];
  int n_cmp = 0, n_err = 0;
  int phase = 0;             // 0 idle, 1 waiting for SOF, 2 streaming, 3 done
  bit done_exp = 0, err_exp = 0;
  int pos = 0, pix_cnt = 0, mdone = 0, cyc = 0;
  int gap_pct = 0, stall_pct = 0, noise_pct = 0;
  bit start_req = 0, s_hs_prev = 0;
  int done_seen = 0, err_seen = 0, aa_seen = 0;
  int first_hs = 0, last_hs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void push_beat(input logic [DW-1:0] d);
    for (int j = 0; j < PPB; j++) begin
      pix_t p;
      p.data = int'(d[8*j +: 8]);
      p.col  = pos % COLS;
      p.row  = pos / COLS;
      p.last = (pos == NPIX - 1) ? 1 : 0;
      exp_q.push_back(p);
      pos++;
    end
  endfunction

  task automatic build_frame(input int base, input bit rnd, input int sof_after);
    for (int b = 0; b < NPIX / PPB; b++) begin
      beat_t bt;
      bt.tuser = (b == 0);
      bt.after = (b == 0) ? sof_after : 0;
      for (int j = 0; j < PPB; j++)
        bt.data[8*j +: 8] = rnd ? 8'($urandom) : 8'(base + b * PPB + j);
      src_q.push_back(bt);
    end
  endtask

  task automatic add_junk(input int n);
    for (int k = 0; k < n; k++) begin
      beat_t bt;
      bt.tuser = 1'b0;
      bt.after = 0;
      bt.data  = {PPB{8'hAA}};
      src_q.push_back(bt);
    end
  endtask

  // One clock: drive after the edge, check and advance the model at the falling edge.
  task automatic tick();
    bit s_hs, m_hs, exp_tv, exp_tr;
    pix_t cur;
    if (s_hs_prev) s_axis_tvalid = 1'b0;
    if (!s_axis_tvalid && src_q.size() > 0) begin
      if (pix_cnt >= src_q[0].after && $urandom_range(99, 0) >= gap_pct) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = src_q[0].data;
        s_axis_tuser  = src_q[0].tuser;
      end
    end
    m_axis_tready = ($urandom_range(99, 0) >= stall_pct);
    ap_start = start_req || (phase != 0 && $urandom_range(99, 0) < noise_pct);
    start_req = 0;
    @(negedge clk);
    cyc++;
    exp_tv = (phase == 2) && (exp_q.size() > 0);
    if (phase == 1) exp_tr = 1;
    else if (phase == 2)
      exp_tr = (exp_q.size() == 0) || (exp_q.size() == 1 && m_axis_tready && exp_q[0].last == 0);
    else exp_tr = 0;
    check("ap_idle", ap_idle, (phase == 0));
    check("ap_done", ap_done, done_exp);
    check("frame_err", frame_err, err_exp);
    check("m_tvalid", m_axis_tvalid, exp_tv);
    check("s_tready", s_axis_tready, exp_tr);
    if (exp_tv) begin
      cur = exp_q[0];
      check("pix_data", m_axis_tdata, cur.data);
      check("pix_col", cnt_col, cur.col);
      check("pix_row", cnt_row, cur.row);
      check("pix_last", m_axis_tlast, cur.last);
    end else begin
      check("tlast_idle", m_axis_tlast, 0);
    end
    if (ap_done) done_seen++;
    if (frame_err) err_seen++;
    if (m_axis_tvalid && m_axis_tdata == 8'hAA) aa_seen++;
    s_hs = s_axis_tvalid && exp_tr;
    m_hs = exp_tv && m_axis_tready;
    s_hs_prev = s_hs;
    done_exp = 0;
    err_exp  = 0;
    case (phase)
      0: if (ap_start) phase = 1;
      1: if (s_hs && s_axis_tuser) begin
           pos = 0;
           push_beat(s_axis_tdata);
           phase = 2;
         end
      2: begin
        if (m_hs) begin
          cur = exp_q.pop_front();
          pix_cnt++;
          if (cur.col == 0 && cur.row == 0) first_hs = cyc;
          if (cur.last != 0) begin
            last_hs = cyc;
            phase = 3;
            done_exp = 1;
            mdone++;
            exp_q.delete();
          end
        end
        if (s_hs) begin
          if (s_axis_tuser) begin
            exp_q.delete();
            pos = 0;
            err_exp = 1;
          end
          push_beat(s_axis_tdata);
        end
      end
      3: phase = 0;
      default: phase = 0;
    endcase
    if (s_hs) void'(src_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic run_frames(input int n);
    int guard = 0;
    int goal  = mdone + n;
    while ((mdone < goal || phase != 0) && guard < 3000) begin
      tick();
      guard++;
    end
    check("cycle_budget", (guard < 3000), 1);
  endtask

  task automatic check_reset(input string pre);
    check({pre, "ap_idle"}, ap_idle, 1);
    check({pre, "ap_done"}, ap_done, 0);
    check({pre, "frame_err"}, frame_err, 0);
    check({pre, "m_tvalid"}, m_axis_tvalid, 0);
    check({pre, "s_tready"}, s_axis_tready, 0);
    check({pre, "m_tdata"}, m_axis_tdata, 0);
    check({pre, "m_tlast"}, m_axis_tlast, 0);
    check({pre, "cnt_col"}, cnt_col, 0);
    check({pre, "cnt_row"}, cnt_row, 0);
  endtask

  task automatic new_test(input int gap, input int stall, input int noise);
    gap_pct = gap; stall_pct = stall; noise_pct = noise;
    pix_cnt = 0; done_seen = 0; err_seen = 0; aa_seen = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // T1: ramp frame, continuous flow
    new_test(0, 0, 0);
    build_frame(0, 0, 0);
    start_req = 1;
    run_frames(1);
    check("t1_span", last_hs - first_hs, NPIX - 1);
    check("t1_done_cnt", done_seen, 1);

    // T2: same frame with upstream gaps and downstream stalls
    new_test(40, 50, 0);
    build_frame(0, 0, 0);
    start_req = 1;
    run_frames(1);
    check("t2_done_cnt", done_seen, 1);

    // T3: two non-SOF beats ahead of the SOF are dropped
    new_test(0, 0, 0);
    add_junk(2);
    build_frame(0, 0, 0);
    start_req = 1;
    run_frames(1);
    check("t3_aa_seen", aa_seen, 0);
    check("t3_done_cnt", done_seen, 1);

    // T4: a second SOF offered after 10 pixels restarts the frame
    new_test(0, 0, 0);
    build_frame(0, 0, 0);
    while (src_q.size() > 3) void'(src_q.pop_back());
    build_frame(100, 0, 10);
    start_req = 1;
    run_frames(1);
    check("t4_err_cnt", err_seen, 1);
    check("t4_done_cnt", done_seen, 1);

    // T5: reset pulse at pixel 17, then a clean replay of T1
    new_test(0, 0, 0);
    build_frame(0, 0, 0);
    start_req = 1;
    begin
      int g = 0;
      while (pix_cnt < 17 && g < 500) begin
        tick();
        g++;
      end
      check("t5_reach17", pix_cnt, 17);
    end
    reset = 1'b0;
    #1;
    check_reset("t5_");
    @(posedge clk);
    #1;
    reset = 1'b1;
    src_q.delete(); exp_q.delete();
    s_axis_tvalid = 1'b0; s_hs_prev = 0;
    phase = 0; done_exp = 0; err_exp = 0;
    new_test(0, 0, 0);
    build_frame(0, 0, 0);
    start_req = 1;
    run_frames(1);
    check("t5_span", last_hs - first_hs, NPIX - 1);
    check("t5_done_cnt", done_seen, 1);

    // T6: random frames with spurious ap_start during streaming
    new_test(30, 30, 30);
    for (int f = 0; f < 4; f++) begin
      add_junk($urandom_range(2, 0));
      build_frame(0, 1, 0);
      start_req = 1;
      run_frames(1);
    end
    check("t6_done_cnt", done_seen, 4);
    check("t6_err_cnt", err_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
